// File: rtl/rv32_m_pkg.sv
// Shared RV32M divide definitions: operand width, div_op encodings and divider FSM states.
package rv32_m_pkg;
  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] DIV_OVF_DIVIDEND = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {
    OP_DIV  = 2'b00,
    OP_DIVU = 2'b01,
    OP_REM  = 2'b10,
    OP_REMU = 2'b11
  } div_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    DONE = 2'b10
  } div_state_t;

  function automatic logic [XLEN-1:0] abs_val(input logic [XLEN-1:0] v, input logic is_signed);
    return (is_signed && v[XLEN-1]) ? -v : v;
  endfunction
endpackage

// File: rtl/div_step.sv
// One restoring division step: shift the next dividend bit into the partial remainder, subtract if it fits.
module div_step
  import rv32_m_pkg::*;
(
  input  logic [XLEN-1:0] i_rem,
  input  logic [XLEN-1:0] i_quo,
  input  logic [XLEN-1:0] i_divisor,
  output logic [XLEN-1:0] o_rem,
  output logic [XLEN-1:0] o_quo
);
  // One extra bit: the shifted remainder can exceed XLEN bits when the divisor is above 2^(XLEN-1).
  logic [XLEN:0]   w_shift;
  logic [XLEN-1:0] w_diff;

  always_comb begin
    w_shift = {i_rem, i_quo[XLEN-1]};
    w_diff  = w_shift[XLEN-1:0] - i_divisor;
    if (w_shift >= {1'b0, i_divisor}) begin
      o_rem = w_diff;
      o_quo = {i_quo[XLEN-2:0], 1'b1};
    end else begin
      o_rem = w_shift[XLEN-1:0];
      o_quo = {i_quo[XLEN-2:0], 1'b0};
    end
  end
endmodule

// File: rtl/div_unit.sv
// Iterative radix-2 RV32M divider (DIV/DIVU/REM/REMU) with pipeline stall handshake.
// Optional DIV_RESULT_CACHE_EN: reuse last quotient/remainder for repeated operands.
module div_unit
  import rv32_m_pkg::*;
(
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_start,
  input  logic [1:0]      i_div_op,
  input  logic [XLEN-1:0] i_op_a,
  input  logic [XLEN-1:0] i_op_b,
  input  logic            i_flush,
  output logic [XLEN-1:0] o_res,
  output logic            o_div_stall,
  output logic            o_done
);
  localparam int CW = $clog2(XLEN);

  div_state_t      r_state, w_next;
  logic [CW-1:0]   r_count;
  logic [XLEN-1:0] r_rem, r_quo, r_absb, r_res;
  logic            r_neg_q, r_neg_r, r_is_rem;

  logic            w_signed, w_is_rem, w_go, w_b_zero, w_ovf, w_special;
  logic [XLEN-1:0] w_abs_a, w_abs_b, w_sp_quo, w_sp_rem;
  logic [XLEN-1:0] w_step_rem, w_step_quo, w_fin_quo, w_fin_rem;
  logic            w_hit;
  logic [XLEN-1:0] w_hit_quo, w_hit_rem;

  assign w_signed  = ~i_div_op[0];
  assign w_is_rem  = i_div_op[1];
  assign w_go      = i_start & ~i_flush;
  assign w_abs_a   = abs_val(i_op_a, w_signed);
  assign w_abs_b   = abs_val(i_op_b, w_signed);
  assign w_b_zero  = (i_op_b == '0);
  assign w_ovf     = w_signed & (i_op_a == DIV_OVF_DIVIDEND) & (&i_op_b);
  assign w_special = w_b_zero | w_ovf;
  assign w_sp_quo  = w_b_zero ? '1 : DIV_OVF_DIVIDEND;
  assign w_sp_rem  = w_b_zero ? i_op_a : '0;

  div_step u_step (
    .i_rem     (r_rem),
    .i_quo     (r_quo),
    .i_divisor (r_absb),
    .o_rem     (w_step_rem),
    .o_quo     (w_step_quo)
  );

  assign w_fin_quo = r_neg_q ? -w_step_quo : w_step_quo;
  assign w_fin_rem = r_neg_r ? -w_step_rem : w_step_rem;

`ifdef DIV_RESULT_CACHE_EN
  logic            r_c_valid, r_c_signed, r_key_signed;
  logic [XLEN-1:0] r_c_a, r_c_b, r_c_quo, r_c_rem, r_key_a, r_key_b;

  assign w_hit     = r_c_valid & (r_c_a == i_op_a) & (r_c_b == i_op_b) & (r_c_signed == w_signed);
  assign w_hit_quo = r_c_quo;
  assign w_hit_rem = r_c_rem;

  // Flush leaves the cache alone: a completed result stays correct for its operands.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_c_valid    <= 1'b0;
      r_c_signed   <= 1'b0;
      r_c_a        <= '0;
      r_c_b        <= '0;
      r_c_quo      <= '0;
      r_c_rem      <= '0;
      r_key_a      <= '0;
      r_key_b      <= '0;
      r_key_signed <= 1'b0;
    end else begin
      if (r_state == IDLE && w_go) begin
        r_key_a      <= i_op_a;
        r_key_b      <= i_op_b;
        r_key_signed <= w_signed;
        if (w_special && !w_hit) begin
          r_c_valid  <= 1'b1;
          r_c_a      <= i_op_a;
          r_c_b      <= i_op_b;
          r_c_signed <= w_signed;
          r_c_quo    <= w_sp_quo;
          r_c_rem    <= w_sp_rem;
        end
      end
      if (r_state == CALC && !i_flush && r_count == '0) begin
        r_c_valid  <= 1'b1;
        r_c_a      <= r_key_a;
        r_c_b      <= r_key_b;
        r_c_signed <= r_key_signed;
        r_c_quo    <= w_fin_quo;
        r_c_rem    <= w_fin_rem;
      end
    end
  end
`else
  assign w_hit     = 1'b0;
  assign w_hit_quo = '0;
  assign w_hit_rem = '0;
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_go) w_next = (w_special || w_hit) ? DONE : CALC;
      CALC:    if (r_count == '0) w_next = DONE;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
    if (i_flush) w_next = IDLE;
  end

  assign o_div_stall = i_rst_n & ((r_state == CALC) | ((r_state == IDLE) & w_go));
  assign o_done      = (r_state == DONE) & ~i_flush;
  assign o_res       = r_res;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_count  <= '0;
      r_rem    <= '0;
      r_quo    <= '0;
      r_absb   <= '0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_is_rem <= 1'b0;
      r_res    <= '0;
    end else begin
      case (r_state)
        IDLE: if (w_go) begin
          r_rem    <= '0;
          r_quo    <= w_abs_a;
          r_absb   <= w_abs_b;
          r_neg_q  <= w_signed & (i_op_a[XLEN-1] ^ i_op_b[XLEN-1]);
          r_neg_r  <= w_signed & i_op_a[XLEN-1];
          r_is_rem <= w_is_rem;
          r_count  <= CW'(XLEN - 1);
          if (w_hit)          r_res <= w_is_rem ? w_hit_rem : w_hit_quo;
          else if (w_special) r_res <= w_is_rem ? w_sp_rem : w_sp_quo;
        end
        CALC: if (!i_flush) begin
          r_rem <= w_step_rem;
          r_quo <= w_step_quo;
          if (r_count == '0) r_res   <= r_is_rem ? w_fin_rem : w_fin_quo;
          else               r_count <= r_count - 1'b1;
        end
        default: ;
      endcase
    end
  end

  a_start_held: assert property (@(posedge i_clk) disable iff (!i_rst_n)
    (r_state == CALC && !i_flush) |-> i_start);
endmodule

// File: tb/tb_div_unit.sv
// Directed self-checking bench for div_unit; expected stall counts follow DIV_RESULT_CACHE_EN.
module tb_div_unit;
  logic        i_clk, i_rst_n, i_start, i_flush;
  logic [1:0]  i_div_op;
  logic [31:0] i_op_a, i_op_b, o_res;
  logic        o_div_stall, o_done;
  int          n_cmp, n_mis;

`ifdef DIV_RESULT_CACHE_EN
  localparam logic [31:0] REM_AFTER_DIV_STALL = 32'd1;
`else
  localparam logic [31:0] REM_AFTER_DIV_STALL = 32'd33;
`endif

  div_unit dut (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_start     (i_start),
    .i_div_op    (i_div_op),
    .i_op_a      (i_op_a),
    .i_op_b      (i_op_b),
    .i_flush     (i_flush),
    .o_res       (o_res),
    .o_div_stall (o_div_stall),
    .o_done      (o_done)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Issue one op from IDLE, count stall cycles until done, check result and single-cycle pulse.
  task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_res,
                        input logic [31:0] exp_stall);
    logic [31:0] stalls;
    logic [31:0] got;
    stalls   = '0;
    got      = '0;
    i_start  = 1'b1;
    i_div_op = op;
    i_op_a   = a;
    i_op_b   = b;
    for (int c = 0; c < 40; c++) begin
      @(negedge i_clk);
      if (o_done) begin
        got = 32'd1;
        break;
      end
      if (o_div_stall) stalls++;
      @(posedge i_clk);
      #1;
    end
    chk({tag, "_done"}, got, 32'd1);
    chk({tag, "_res"}, o_res, exp_res);
    chk({tag, "_stalls"}, stalls, exp_stall);
    chk({tag, "_stall_in_done"}, 32'(o_div_stall), 32'd0);
    @(posedge i_clk);
    #1;
    i_start = 1'b0;
    @(negedge i_clk);
    chk({tag, "_done_pulse"}, 32'(o_done), 32'd0);
    @(posedge i_clk);
    #1;
  endtask

  initial begin
    logic [31:0] pulses;
    n_cmp    = 0;
    n_mis    = 0;
    i_rst_n  = 1'b0;
    i_start  = 1'b0;
    i_flush  = 1'b0;
    i_div_op = 2'b00;
    i_op_a   = '0;
    i_op_b   = '0;
    #12;
    chk("rst_res", o_res, 32'd0);
    chk("rst_done", 32'(o_done), 32'd0);
    chk("rst_stall", 32'(o_div_stall), 32'd0);
    i_rst_n = 1'b1;
    @(posedge i_clk);
    #1;

    run_op("div_20_m3",   2'b00, 32'd20,        32'hFFFF_FFFD, 32'hFFFF_FFFA, 32'd33);
    run_op("rem_m20_3",   2'b10, 32'hFFFF_FFEC, 32'd3,        32'hFFFF_FFFE, 32'd33);
    run_op("remu_max_2",  2'b11, 32'hFFFF_FFFF, 32'd2,        32'd1,         32'd33);
    run_op("divu_max_2",  2'b01, 32'hFFFF_FFFF, 32'd2,        32'h7FFF_FFFF, 32'd33);
    run_op("rem_7_m2",    2'b10, 32'd7,         32'hFFFF_FFFE, 32'd1,        32'd33);
    run_op("divu_big",    2'b01, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,        32'd33);
    run_op("div_7_0",     2'b00, 32'd7,         32'd0,        32'hFFFF_FFFF, 32'd1);
    run_op("rem_7_0",     2'b10, 32'd7,         32'd0,        32'd7,         32'd1);
    run_op("divu_0_0",    2'b01, 32'd0,         32'd0,        32'hFFFF_FFFF, 32'd1);
    run_op("div_ovf",     2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd1);
    run_op("rem_ovf",     2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,        32'd1);
    run_op("div_100_7",   2'b00, 32'd100,       32'd7,        32'd14,        32'd33);
    run_op("rem_100_7",   2'b10, 32'd100,       32'd7,        32'd2,         REM_AFTER_DIV_STALL);

    // Flush on CALC cycle 10: unit returns to IDLE, result register untouched, no done.
    i_start  = 1'b1;
    i_div_op = 2'b00;
    i_op_a   = 32'd1000;
    i_op_b   = 32'd3;
    @(posedge i_clk);
    repeat (9) @(posedge i_clk);
    #1;
    chk("flush_pre_stall", 32'(o_div_stall), 32'd1);
    i_flush = 1'b1;
    @(posedge i_clk);
    #1;
    i_flush = 1'b0;
    i_start = 1'b0;
    @(negedge i_clk);
    chk("flush_stall", 32'(o_div_stall), 32'd0);
    chk("flush_done", 32'(o_done), 32'd0);
    pulses = '0;
    for (int c = 0; c < 40; c++) begin
      @(negedge i_clk);
      if (o_done) pulses++;
    end
    chk("flush_no_done", pulses, 32'd0);
    chk("flush_res_kept", o_res, 32'd2);

    // Reset mid-CALC with start still held: outputs clear without waiting for a clock.
    @(posedge i_clk);
    #1;
    i_start  = 1'b1;
    i_div_op = 2'b01;
    i_op_a   = 32'd1000;
    i_op_b   = 32'd3;
    repeat (6) @(posedge i_clk);
    #1;
    i_rst_n = 1'b0;
    #1;
    chk("mrst_res", o_res, 32'd0);
    chk("mrst_done", 32'(o_done), 32'd0);
    chk("mrst_stall", 32'(o_div_stall), 32'd0);
    i_start = 1'b0;
    @(negedge i_clk);
    i_rst_n = 1'b1;
    @(posedge i_clk);
    #1;
    run_op("divu_after_rst", 2'b01, 32'd1000, 32'd3, 32'd333, 32'd33);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end
endmodule
